// File: rtl/mac_accumulator_pkg.sv
// Shared defaults, FSM encoding and saturation limits for the MAC accumulator.
package mac_accumulator_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned ACC_W_DEF  = 40;
    localparam int unsigned CNT_W_DEF  = 8;

    // 2-bit state encoding, fixed so debug dumps decode consistently
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

    // Clamp limits for the default DATA_W
    localparam logic [DATA_W_DEF-1:0] SAT_MAX_DEF = 16'h7FFF;
    localparam logic [DATA_W_DEF-1:0] SAT_MIN_DEF = 16'h8000;

endpackage

// File: rtl/mac_saturate.sv
// Combinational signed clamp from ACC_W to DATA_W.
module mac_saturate
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    output logic [DATA_W-1:0] sat_c_o
);

    localparam int unsigned HI_W = ACC_W - DATA_W + 1;

    logic [HI_W-1:0] hi_c;
    logic            in_range_c;

    // Value fits when all bits from the result sign bit upward agree
    assign hi_c       = acc_i[ACC_W-1:DATA_W-1];
    assign in_range_c = (hi_c == '0) || (hi_c == '1);

    // Pass through in range, otherwise clamp toward the accumulator's sign
    always_comb begin
        sat_c_o = acc_i[DATA_W-1:0];
        if (!in_range_c) begin
            if (acc_i[ACC_W-1]) begin
                sat_c_o = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat_c_o = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Multiply-accumulate stage feeding the activation unit: sums cfg_len
// Q-format weight*input products, saturates and holds under valid/ready.
// Optional build macro: MAC_BIAS_EN (adds bias_in, preloaded into acc on start).
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_len,
`ifdef MAC_BIAS_EN
    input  logic [DATA_W-1:0] bias_in,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] in_weight,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    mac_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  prod_q, prod_d;
    logic              prod_vld_q, prod_vld_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              busy_q, busy_d;

    logic signed [PROD_W-1:0] prod_full_c;
    logic signed [PROD_W-1:0] prod_shift_c;
    logic [ACC_W-1:0]         prod_ext_c;
    logic [ACC_W-1:0]         start_acc_c;
    logic [ACC_W-1:0]         acc_sum_c;
    logic [ACC_W-1:0]         sat_in_c;
    logic [DATA_W-1:0]        sat_c;
    logic                     hs_c;

    // Fixed-point product: full-width signed multiply, rescale, sign-extend
    assign prod_full_c  = PROD_W'($signed(in_data)) * PROD_W'($signed(in_weight));
    assign prod_shift_c = prod_full_c >>> FRAC_W;
    assign prod_ext_c   = {{(ACC_W-PROD_W){prod_shift_c[PROD_W-1]}}, prod_shift_c};

    // Accumulator start value: sign-extended bias or zero
`ifdef MAC_BIAS_EN
    assign start_acc_c = {{(ACC_W-DATA_W){bias_in[DATA_W-1]}}, bias_in};
`else
    assign start_acc_c = '0;
`endif

    // Stage-2 sum and the value the clamp sees on the cycle the result is captured
    assign acc_sum_c = acc_q + (prod_vld_q ? prod_q : '0);
    assign sat_in_c  = (state_q == ST_IDLE) ? start_acc_c : acc_sum_c;
    assign hs_c      = in_valid && in_ready_q;

    mac_saturate #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_sat (
        .acc_i   (sat_in_c),
        .sat_c_o (sat_c)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_vld_d  = 1'b0;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b0;
                if (start) begin
                    cnt_d = cfg_len;
                    acc_d = start_acc_c;
                    if (cfg_len == '0) begin
                        state_d     = ST_OUT;
                        out_valid_d = 1'b1;
                        out_data_d  = sat_c;
                    end else begin
                        state_d    = ST_ACCUM;
                        in_ready_d = 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                acc_d = acc_sum_c;
                if (hs_c) begin
                    prod_d     = prod_ext_c;
                    prod_vld_d = 1'b1;
                    cnt_d      = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        in_ready_d = 1'b0;
                        state_d    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                acc_d       = acc_sum_c;
                out_data_d  = sat_c;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_vld_q  <= prod_vld_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with immediate-assertion checks.
module tb_mac_accumulator;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic [7:0]  cfg_len   = 8'd0;
    logic        in_valid  = 1'b0;
    logic [15:0] in_data   = 16'h0000;
    logic [15:0] in_weight = 16'h0000;
    logic        out_ready = 1'b0;
`ifdef MAC_BIAS_EN
    logic [15:0] bias_in   = 16'h0000;
`endif
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_len   (cfg_len),
`ifdef MAC_BIAS_EN
        .bias_in   (bias_in),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_weight (in_weight),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        tick();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [15:0] a, input logic [15:0] w);
        chk1("feed_ready", in_ready, 1'b1);
        in_data   = a;
        in_weight = w;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("consume_valid", out_valid, 1'b0);
        chk1("consume_busy", busy, 1'b0);
    endtask

    initial begin
        int hs;
        int budget;
        logic rdy_now;

        // Reset state
        #2;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk16("rst_out_data", out_data, 16'h0000);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Reset mid-accumulation after 2 of 4 terms
        do_start(8'd4);
        chk1("acc_busy", busy, 1'b1);
        feed(16'h0100, 16'h0100);
        feed(16'h0100, 16'h0100);
        #2 rst = 1'b0;
        #1;
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_in_ready", in_ready, 1'b0);
        #2 rst = 1'b1;
        tick();
        do_start(8'd1);
        feed(16'h0200, 16'h0300);
        chk1("one_drain_valid", out_valid, 1'b0);
        tick();
        chk1("one_out_valid", out_valid, 1'b1);
        chk16("one_out_data", out_data, 16'h0600);
        consume();

        // Back-to-back operands: 1*1 + 2*(-1) + 0.5*4 = 1.0
        do_start(8'd3);
        feed(16'h0100, 16'h0100);
        feed(16'h0200, 16'hFF00);
        feed(16'h0080, 16'h0400);
        chk1("b2b_ready_drop", in_ready, 1'b0);
        chk1("b2b_not_yet", out_valid, 1'b0);
        tick();
        chk1("b2b_out_valid", out_valid, 1'b1);
        chk16("b2b_out_data", out_data, 16'h0100);
        consume();

        // Positive saturation
        do_start(8'd4);
        for (int i = 0; i < 4; i++) feed(16'h7FFF, 16'h7FFF);
        tick();
        chk1("satp_valid", out_valid, 1'b1);
        chk16("satp_data", out_data, 16'h7FFF);
        consume();

        // Negative saturation, then hold under backpressure with ignored starts
        do_start(8'd4);
        for (int i = 0; i < 4; i++) feed(16'h7FFF, 16'h8000);
        tick();
        chk1("satn_valid", out_valid, 1'b1);
        chk16("satn_data", out_data, 16'h8000);
        for (int i = 0; i < 5; i++) begin
            start   = ((i % 2) == 0);
            cfg_len = 8'd2;
            tick();
            chk1("bp_valid", out_valid, 1'b1);
            chk16("bp_data", out_data, 16'h8000);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        start = 1'b0;
        consume();
        tick();
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_ready", in_ready, 1'b0);

        // Zero-length neuron
`ifdef MAC_BIAS_EN
        bias_in = 16'hFF00;
`endif
        do_start(8'd0);
        chk1("len0_valid", out_valid, 1'b1);
        chk1("len0_in_ready", in_ready, 1'b0);
`ifdef MAC_BIAS_EN
        chk16("len0_data", out_data, 16'hFF00);
        bias_in = 16'h0000;
`else
        chk16("len0_data", out_data, 16'h0000);
`endif
        consume();

        // Random in_valid gaps over 8 terms: sum of k*1.0 for k=1..8 = 36.0
        do_start(8'd8);
        hs = 0;
        budget = 0;
        while (hs < 8 && budget < 200) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'((hs + 1) * 64);
            in_weight = 16'h0400;
            rdy_now   = in_ready;
            tick();
            if (in_valid && rdy_now) hs++;
            budget++;
        end
        chk16("rnd_handshakes", 16'(hs), 16'd8);
        chk1("rnd_ready_after", in_ready, 1'b0);
        in_valid = 1'b1;
        rdy_now  = in_ready;
        tick();
        if (in_valid && rdy_now) hs++;
        in_valid = 1'b0;
        chk16("rnd_no_extra_hs", 16'(hs), 16'd8);
        chk1("rnd_valid", out_valid, 1'b1);
        chk16("rnd_data", out_data, 16'h2400);
        consume();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
